// File: rtl/rh_dma_ctl.sv
// Word-at-a-time DMA sequencer between a data buffer and an 18-bit bus.
// Optional bus-timeout (non-existent memory) detection when RH_DMA_CTL_TIMEOUT_EN is defined.
module rh_dma_ctl #(
    parameter int TMO_CYCLES = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rhCLR,
    input  logic        rhGO,
    input  logic        rhFUN,
    input  logic [15:0] rhWCIN,
    input  logic [17:0] rhBAIN,
    input  logic        rhBAI,
    input  logic        bufIR,
    input  logic        bufOR,
    input  logic        dmaACK,
    output logic        dmaREQ,
    output logic        dmaWR,
    output logic [17:0] dmaADDR,
    output logic        bufPUSH,
    output logic        bufPOP,
    output logic [15:0] rhWC,
    output logic [17:0] rhBA,
    output logic        rhBUSY,
    output logic        rhDONE,
    output logic        rhNXM
);

    typedef enum logic [2:0] {S_IDLE, S_ARB, S_REQ, S_STEP, S_DONE} state_t;

    state_t      state_q, state_d;
    logic        fun_q, inh_q;
    logic [15:0] wc_q, wc_inc;
    logic [17:0] ba_q;
    logic        start;
    logic        tmo;

    assign start  = (state_q == S_IDLE) && rhGO && !rhCLR;
    assign wc_inc = wc_q + 16'd1;

`ifdef RH_DMA_CTL_TIMEOUT_EN
    localparam int CW = $clog2(TMO_CYCLES + 1);
    logic [CW-1:0] tmo_cnt_q;
    logic          nxm_q;

    // Counter sits at zero outside REQ, so every entry into REQ starts a fresh count.
    assign tmo = (state_q == S_REQ) && !dmaACK && (tmo_cnt_q == CW'(TMO_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst || state_q != S_REQ)
            tmo_cnt_q <= '0;
        else if (!dmaACK)
            tmo_cnt_q <= tmo_cnt_q + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst || rhCLR || start)
            nxm_q <= 1'b0;
        else if (tmo)
            nxm_q <= 1'b1;
    end

    assign rhNXM = nxm_q;
`else
    assign tmo   = 1'b0;
    assign rhNXM = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (rhGO) state_d = S_ARB;
            S_ARB:  if (fun_q ? bufOR : bufIR) state_d = S_REQ;
            S_REQ: begin
                if (dmaACK)   state_d = S_STEP;
                else if (tmo) state_d = S_DONE;
            end
            S_STEP: state_d = (wc_inc == 16'd0) ? S_DONE : S_ARB;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (rhCLR) state_d = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst || rhCLR) begin
            wc_q  <= '0;
            ba_q  <= '0;
            fun_q <= 1'b0;
            inh_q <= 1'b0;
        end else if (start) begin
            wc_q  <= rhWCIN;
            ba_q  <= rhBAIN;
            fun_q <= rhFUN;
            inh_q <= rhBAI;
        end else if (state_q == S_STEP) begin
            wc_q <= wc_inc;
            if (!inh_q) ba_q <= ba_q + 18'd2;
        end
    end

    always_comb begin
        dmaREQ  = 1'b0;
        dmaWR   = 1'b0;
        bufPUSH = 1'b0;
        bufPOP  = 1'b0;
        rhDONE  = 1'b0;
        rhBUSY  = (state_q != S_IDLE);
        case (state_q)
            S_REQ: begin
                dmaREQ = 1'b1;
                dmaWR  = fun_q;
            end
            S_STEP: begin
                bufPUSH = !fun_q;
                bufPOP  = fun_q;
            end
            S_DONE: rhDONE = 1'b1;
            default: ;
        endcase
    end

    assign dmaADDR = ba_q;
    assign rhWC    = wc_q;
    assign rhBA    = ba_q;

endmodule

// File: doc/rh_dma_ctl.md
RH_DMA_CTL -- requirements
Module: rh_dma_ctl

Interface
REQ-001 Parameter TMO_CYCLES, default 1023: cycles the block waits for dmaACK before it declares non-existent memory.
REQ-002 clk  in  1  system clock; all logic on rising edge.
REQ-003 rst  in  1  reset; synchronous, active-high.
REQ-004 rhCLR  in  1  controller clear; synchronous abort.
REQ-005 rhGO  in  1  one-cycle start pulse.
REQ-006 rhFUN  in  1  0 = memory-to-buffer (drive write), 1 = buffer-to-memory (drive read); sampled on rhGO.
REQ-007 rhWCIN  in  16  two's-complement negative word count; sampled on rhGO.
REQ-008 rhBAIN  in  18  starting byte bus address; sampled on rhGO.
REQ-009 rhBAI  in  1  bus address increment inhibit; sampled on rhGO.
REQ-010 bufIR  in  1  data buffer has room (not full).
REQ-011 bufOR  in  1  data buffer has data (not empty).
REQ-012 dmaACK  in  1  bus grant/complete for the current word.
REQ-013 dmaREQ  out  1  bus cycle request.
REQ-014 dmaWR  out  1  1 = memory write, 0 = memory read.
REQ-015 dmaADDR  out  18  current bus address (equals rhBA).
REQ-016 bufPUSH  out  1  one-cycle write strobe into the data buffer.
REQ-017 bufPOP  out  1  one-cycle read strobe from the data buffer.
REQ-018 rhWC  out  16  live word count; rhBA  out  18  live bus address.
REQ-019 rhBUSY  out  1  transfer in progress; rhDONE  out  1  one-cycle completion pulse; rhNXM  out  1  sticky timeout error.

Function
REQ-020 States SHALL be IDLE, ARB, REQ, STEP, DONE.
REQ-021 IDLE: rhGO loads rhWC, rhBA, direction and inhibit, clears rhNXM, enters ARB next cycle; rhBUSY=1 from that cycle until IDLE is re-entered.
REQ-022 ARB: rhFUN=0 waits for bufIR=1; rhFUN=1 waits for bufOR=1; then REQ.
REQ-023 REQ: dmaREQ=1, dmaWR=rhFUN, held stable until the cycle dmaACK=1 is sampled; then STEP.
REQ-024 STEP (exactly one cycle): bufPUSH=1 if rhFUN=0, bufPOP=1 if rhFUN=1; dmaREQ=0; rhWC increments by 1; rhBA increments by 2 modulo 2^18 unless inhibit is set.
REQ-025 STEP: if the incremented rhWC equals 0, go to DONE; otherwise go to ARB.
REQ-026 rhWCIN=0 SHALL transfer 65536 words.
REQ-027 DONE: rhDONE=1 for one cycle; then IDLE.
REQ-028 Minimum per-word throughput: 3 cycles (ARB, REQ with immediate ACK, STEP).
REQ-029 rhGO while rhBUSY=1 SHALL be ignored.
REQ-030 rhCLR in any state: next state IDLE; dmaREQ, bufPUSH and bufPOP deassert next cycle; rhWC, rhBA and rhNXM cleared; no rhDONE.
REQ-031 rhCLR and rhGO in the same cycle: rhCLR wins and the transfer does not start.
REQ-032 dmaACK outside REQ SHALL be ignored.

Reset
REQ-033 With rst=1, at the next edge: state=IDLE; all outputs 0 (dmaREQ, dmaWR, dmaADDR, bufPUSH, bufPOP, rhWC, rhBA, rhBUSY, rhDONE, rhNXM).
REQ-034 Reset mid-transfer SHALL behave as rhCLR and produce no rhDONE pulse.

Configuration
REQ-035 With macro RH_DMA_CTL_TIMEOUT_EN defined: a counter clears on entry to REQ and counts each REQ cycle without dmaACK. On reaching TMO_CYCLES: rhNXM=1 (sticky), dmaREQ drops, no push or pop occurs, state goes to DONE, and rhDONE pulses.
REQ-036 Without RH_DMA_CTL_TIMEOUT_EN: REQ waits indefinitely, rhNXM is constant 0, and no counter logic is synthesized.

Verification
REQ-037 rhGO, rhFUN=0, rhWCIN=16'o177775 (-3), rhBAIN=18'o1000, bufIR=1, dmaACK immediate -> 3 bufPUSH pulses at BA 1000/1002/1004, final rhWC=0, rhBA=18'o1006, rhDONE one pulse.
REQ-038 rhFUN=1, rhWCIN=-2, bufOR=0 for 10 cycles, then 1 -> no dmaREQ until bufOR=1, then 2 bufPOP pulses with dmaWR=1.
REQ-039 rhBAI=1, rhWCIN=-4, rhBAIN=18'o777776 -> dmaADDR stays 777776 for all 4 words; with rhBAI=0 the second word is at address 0 (wrap).
REQ-040 rhCLR asserted in REQ of the second word -> dmaREQ=0 next cycle, rhBUSY=0, rhWC=rhBA=0, no rhDONE; rhGO on the same cycle as rhCLR is ignored.
REQ-041 RH_DMA_CTL_TIMEOUT_EN defined, TMO_CYCLES=8, dmaACK held 0 -> rhNXM=1 and rhDONE after 8 REQ cycles, no bufPUSH; next rhGO clears rhNXM.
REQ-042 rhGO pulsed during a busy transfer, and rst mid-transfer -> the second start is ignored; reset gives all outputs 0 at the next edge.
